// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, write-back requester indices and write-port state type
package cpu_pkg;
   localparam int NUM_REGS = 4;
   localparam int REG_SEL_W = 2;
   localparam int DATA_WIDTH = 8;
   localparam int REQ_ALU = 0;
   localparam int REQ_MEM = 1;
   localparam int REQ_IMM = 2;
   typedef enum logic {IDLE, WRITE} wr_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first requester after last, with wrap-around
module rr_picker #(
   parameter int N = 3,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx,
   output logic         valid
);
   logic [W-1:0] i;
   // walk from the farthest candidate to the nearest so the nearest hit is the one that sticks
   always_comb begin
      grant = '0;
      idx = '0;
      valid = 1'b0;
      i = '0;
      for (int k = N; k >= 1; k--) begin
         i = W'((int'(last) + k) % N);
         if (req[i]) begin
            grant = '0;
            grant[i] = 1'b1;
            idx = i;
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin share of the register-file write port among write-back sources.
// Define REG_WRITE_ARBITER_STATS_EN to add the saturating CONTENTION_COUNT output.
module reg_write_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
   parameter int REG_SEL_W = cpu_pkg::REG_SEL_W
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          HOLD,
   input  logic [NUM_REQ-1:0]            REQ,
   input  logic [NUM_REQ*REG_SEL_W-1:0]  REQ_DST,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]            GRANT,
   output logic [REG_SEL_W-1:0]          DST_SELECTION,
   output logic                          LOAD_DST,
   output logic [DATA_WIDTH-1:0]         WRITE_DATA
`ifdef REG_WRITE_ARBITER_STATS_EN
   ,
   output logic [7:0]                    CONTENTION_COUNT
`endif
);
   import cpu_pkg::*;
   localparam int PW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0] pick;
   logic [PW-1:0] pick_idx, last_q;
   logic pick_valid, gnt;
   wr_state_t state_q, state_d;
   rr_picker #(.N(NUM_REQ), .W(PW)) u_pick (
      .req(REQ),
      .last(last_q),
      .grant(pick),
      .idx(pick_idx),
      .valid(pick_valid)
   );
   assign gnt = pick_valid & ~HOLD & ~RST;
   assign GRANT = gnt ? pick : '0;
   always_comb begin
      state_d = gnt ? WRITE : IDLE;
      LOAD_DST = (state_q == WRITE);
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         last_q <= PW'(NUM_REQ - 1);
         DST_SELECTION <= '0;
         WRITE_DATA <= '0;
      end else begin
         state_q <= state_d;
         if (gnt) begin
            last_q <= pick_idx;
            DST_SELECTION <= REQ_DST[pick_idx*REG_SEL_W +: REG_SEL_W];
            WRITE_DATA <= REQ_DATA[pick_idx*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end
`ifdef REG_WRITE_ARBITER_STATS_EN
   logic contended;
   assign contended = ~HOLD && ($countones(REQ) >= 2);
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) CONTENTION_COUNT <= '0;
      else if (contended && CONTENTION_COUNT != 8'hFF) CONTENTION_COUNT <= CONTENTION_COUNT + 8'd1;
   end
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed and random checks of reg_write_arbiter against a round-robin reference model
module tb_reg_write_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hold = 1'b0;
   logic [2:0] req = '0;
   logic [5:0] req_dst = '0;
   logic [23:0] req_data = '0;
   logic [2:0] grant;
   logic [1:0] dst_sel;
   logic load_dst;
   logic [7:0] wdata;
`ifdef REG_WRITE_ARBITER_STATS_EN
   logic [7:0] cont_cnt;
`endif
   int total = 0;
   int bad = 0;
   int m_last = 2;
   logic m_load = 1'b0;
   logic [1:0] m_dst = '0;
   logic [7:0] m_data = '0;
   int m_cc = 0;
   int last_g = -1;

   reg_write_arbiter dut (
      .CLK(clk),
      .RST(rst),
      .HOLD(hold),
      .REQ(req),
      .REQ_DST(req_dst),
      .REQ_DATA(req_data),
      .GRANT(grant),
      .DST_SELECTION(dst_sel),
      .LOAD_DST(load_dst),
      .WRITE_DATA(wdata)
`ifdef REG_WRITE_ARBITER_STATS_EN
      ,
      .CONTENTION_COUNT(cont_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // first requester after 'last' in ascending order with wrap, or -1 when nobody asks
   function automatic int rr_pick(input logic [2:0] r, input int last);
      for (int k = 1; k <= 3; k++)
         if (((r >> ((last + k) % 3)) & 3'b001) != 3'b000) return (last + k) % 3;
      return -1;
   endfunction

   // called at posedge+1 with inputs already driven; returns at the next posedge+1
   task automatic cycle();
      int g;
      #1;
      g = hold ? -1 : rr_pick(req, m_last);
      chk("grant", 32'(grant), g < 0 ? 32'd0 : 32'(1 << g));
      if (!hold && $countones(req) >= 2 && m_cc < 255) m_cc++;
      @(posedge clk);
      if (g >= 0) begin
         m_load = 1'b1;
         m_dst = 2'(req_dst >> (2 * g));
         m_data = 8'(req_data >> (8 * g));
         m_last = g;
      end else m_load = 1'b0;
      last_g = g;
      #1;
      chk("load_dst", 32'(load_dst), 32'(m_load));
      chk("dst_sel", 32'(dst_sel), 32'(m_dst));
      chk("wdata", 32'(wdata), 32'(m_data));
`ifdef REG_WRITE_ARBITER_STATS_EN
      chk("ccount", 32'(cont_cnt), 32'(m_cc));
`endif
   endtask

   task automatic model_reset();
      m_last = 2;
      m_load = 1'b0;
      m_dst = '0;
      m_data = '0;
      m_cc = 0;
   endtask

   initial begin
      logic [2:0] pend;
      int saw2;
      req = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_load", 32'(load_dst), 32'd0);
      chk("rst_dst", 32'(dst_sel), 32'd0);
      chk("rst_data", 32'(wdata), 32'd0);
      rst = 1'b0;
      req_dst = {2'd2, 2'd1, 2'd0};
      req_data = {8'hC2, 8'hB1, 8'hA0};
      for (int n = 0; n < 3; n++) begin
         cycle();
         chk("rr_order", 32'(last_g), 32'(n));
         chk("rr_load", 32'(load_dst), 32'd1);
      end
      req = 3'b010;
      req_dst = {2'd0, 2'd2, 2'd0};
      req_data = {8'h00, 8'hA5, 8'h00};
      cycle();
      chk("single_dst", 32'(dst_sel), 32'd2);
      chk("single_data", 32'(wdata), 32'hA5);
      chk("single_load", 32'(load_dst), 32'd1);
      req = 3'b101;
      req_data = {8'h5C, 8'h00, 8'h3A};
      saw2 = 0;
      for (int n = 0; n < 4; n++) begin
         cycle();
         if (n < 2 && last_g == 2) saw2 = 1;
         if (last_g == 2) req = 3'b001;
         else req = 3'b101;
      end
      chk("fair_req2", 32'(saw2), 32'd1);
      req = 3'b001;
      hold = 1'b1;
      repeat (4) begin
         cycle();
         chk("hold_load", 32'(load_dst), 32'd0);
      end
      hold = 1'b0;
      cycle();
      chk("unhold_grant", 32'(last_g), 32'd0);
      chk("unhold_load", 32'(load_dst), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_load", 32'(load_dst), 32'd0);
      chk("async_dst", 32'(dst_sel), 32'd0);
      chk("async_data", 32'(wdata), 32'd0);
      chk("async_grant", 32'(grant), 32'd0);
      model_reset();
      req = 3'b000;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      req = 3'b011;
      req_dst = {2'd0, 2'd3, 2'd3};
      req_data = {8'h00, 8'h22, 8'h11};
      cycle();
      chk("waw_first", 32'(wdata), 32'h11);
`ifdef REG_WRITE_ARBITER_STATS_EN
      chk("waw_cc", 32'(cont_cnt), 32'd1);
`endif
      req = 3'b010;
      cycle();
      chk("waw_second", 32'(wdata), 32'h22);
      chk("waw_dst", 32'(dst_sel), 32'd3);
      req = 3'b000;
      pend = '0;
      for (int n = 0; n < 300; n++) begin
         if (last_g >= 0) pend[last_g] = 1'b0;
         for (int i = 0; i < 3; i++)
            if (!pend[i] && $urandom_range(2) == 0) begin
               pend[i] = 1'b1;
               req_dst[2*i +: 2] = 2'($urandom);
               req_data[8*i +: 8] = 8'($urandom);
            end
         req = pend;
         hold = ($urandom_range(4) == 0);
         cycle();
      end
`ifdef REG_WRITE_ARBITER_STATS_EN
      hold = 1'b0;
      req = 3'b111;
      repeat (260) cycle();
      chk("cc_sat", 32'(cont_cnt), 32'd255);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the CPU's single register-file write port between NUM_REQ write-back sources. Sources are ALU, memory load and immediate/move by default.
- Picks one requester per cycle by round-robin and returns a one-cycle GRANT pulse.
- Drives a registered DST_SELECTION / LOAD_DST / WRITE_DATA triple into the load demultiplexer, which fans LOAD_DST out to LOAD_R0..LOAD_R3.
- HOLD input lets the control unit freeze write-back during halt or single-step.

Parameters:
- NUM_REQ, 3, number of write-back requesters; legal range 2..4.
- DATA_WIDTH, 8, register data width.
- REG_SEL_W, 2, width of the destination register index (4 registers).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- HOLD  input  1  while high, no grants are issued and requests stay pending.
- REQ  input  NUM_REQ  per-requester write request; held high until granted.
- REQ_DST  input  NUM_REQ*REG_SEL_W  flattened destination index; requester i occupies slice [i*REG_SEL_W +: REG_SEL_W].
- REQ_DATA  input  NUM_REQ*DATA_WIDTH  flattened write data; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- GRANT  output  NUM_REQ  one-hot, combinational, at most one bit high per cycle.
- DST_SELECTION  output  REG_SEL_W  registered destination index to the load demux.
- LOAD_DST  output  1  registered write enable to the load demux.
- WRITE_DATA  output  DATA_WIDTH  registered data to the register file.

Behaviour:
- Reset (async, RST high):
  - DST_SELECTION=0, LOAD_DST=0, WRITE_DATA=0.
  - Round-robin pointer LAST=NUM_REQ-1, so requester 0 has top priority first.
  - GRANT=0 while RST is high.
- Arbitration, combinational in cycle N:
  - If HOLD=0 and any REQ bit is high, grant the first requesting index after LAST, searching in ascending order with wrap-around.
  - GRANT is valid in the same cycle as REQ.
  - A requester sees GRANT[i]=1 and deasserts or changes its payload on the next edge.
- Handshake:
  - REQ[i], REQ_DST and REQ_DATA must stay stable while REQ[i]=1 and GRANT[i]=0.
  - Back-to-back requests from one source are legal. It is granted again only after the other pending requesters have been served.
- Capture, at the edge ending cycle N:
  - If a grant was issued: LOAD_DST<=1, DST_SELECTION<=REQ_DST[g], WRITE_DATA<=REQ_DATA[g], LAST<=g.
  - Otherwise: LOAD_DST<=0; DST_SELECTION and WRITE_DATA hold their previous values; LAST is unchanged.
- Latency:
  - Grant in cycle N → LOAD_DST high in cycle N+1 → register file updated at the end of N+1.
  - Throughput is one write per cycle.
- States: IDLE (LOAD_DST=0) and WRITE (LOAD_DST=1). WRITE→WRITE is allowed on consecutive grants.
- Boundary conditions:
  - HOLD=1: GRANT=0 and LOAD_DST drops to 0 on the next edge. A write already in the output register still completes that cycle.
  - Requests without a grant are never lost.
  - Two requesters targeting the same register: both are written in arbitration order, so the last grant wins.
  - REQ bits at or above NUM_REQ do not exist. Index wrap uses modulo NUM_REQ.
  - RST mid-write aborts the write: LOAD_DST goes to 0 immediately and asynchronously.

Optional Feature:
- Macro: REG_WRITE_ARBITER_STATS_EN.
- When defined:
  - Adds output CONTENTION_COUNT, 8 bits.
  - Counts every cycle in which HOLD=0 and two or more REQ bits are high.
  - Saturates at 255.
  - Reset value 0, cleared asynchronously by RST.
- When undefined: the port and counter are absent. Arbitration behaviour is identical in both builds.

Decomposition:
- Shared package cpu_pkg:
  - constants NUM_REGS=4, REG_SEL_W=2, DATA_WIDTH=8;
  - localparams for requester indices REQ_ALU=0, REQ_MEM=1, REQ_IMM=2.
- Sub-module rr_picker, combinational: inputs REQ vector and LAST pointer; outputs one-hot GRANT and the encoded index. It is reusable for the future bus arbiter.

Test Plan:
- Reset: assert RST mid-cycle while LOAD_DST=1 → LOAD_DST=0, DST_SELECTION=0, WRITE_DATA=0 immediately; the first grant after release goes to requester 0.
- Single request: REQ=3'b010, DST=2, DATA=8'hA5 → GRANT=3'b010 in the same cycle; next cycle LOAD_DST=1, DST_SELECTION=2, WRITE_DATA=A5.
- Full contention: REQ=3'b111 held for 3 cycles with pointer at reset value → grants 0, 1, 2 in order; LOAD_DST high for 3 consecutive cycles.
- Fairness: requester 0 re-requests every cycle while requester 2 waits → requester 2 is granted within 2 cycles, never starved.
- HOLD: REQ=3'b001 with HOLD=1 for 4 cycles → GRANT=0 and LOAD_DST=0 throughout; release HOLD → grant the same cycle, write the next.
- Same-register WAW: requester 0 (R3, 8'h11) and requester 1 (R3, 8'h22) both pending → writes 11 then 22; with STATS_EN defined, CONTENTION_COUNT=1.
